// File: rtl/branch_checkpoint_ctrl.sv
// Checkpoint FIFO and update/rollback sequencer for a gshare branch predictor.
// Branches are checkpointed at fetch and resolved strictly oldest-first.
module branch_checkpoint_ctrl #(
  parameter int HISTORY_LEN = 8,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [15:0]              fetch_pc,
  output logic                     fetch_ready,
  output logic                     fetch_taken,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     resolve_ready,
  output logic                     mispredict_flush,
  output logic [$clog2(DEPTH):0]   inflight_count,
  input  logic                     gp_prediction,
  input  logic [HISTORY_LEN-1:0]   gp_history,
  output logic [15:0]              gp_pc_read,
  output logic                     gp_predict_enable,
  output logic [15:0]              gp_pc_write,
  output logic [HISTORY_LEN-1:0]   gp_history_write,
  output logic                     gp_write_enabled,
  output logic                     gp_outcome,
  output logic                     gp_rollback_enabled,
  output logic [1:0]               fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, UPDATE = 2'd1, ROLLBACK = 2'd2} state_t;

  state_t state_q, state_d;

  logic [15:0]             pc_mem   [DEPTH];
  logic [HISTORY_LEN-1:0]  hist_mem [DEPTH];
  logic                    pred_mem [DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    mispredict_q;
  logic                    fetch_fire, resolve_fire, start_rollback;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and valid may wait for ready.
  assign fetch_ready   = ((state_q == IDLE) || (state_q == UPDATE && !mispredict_q)) &&
                         (inflight_count < DEPTH_C);
  assign resolve_ready = (state_q == IDLE) && (inflight_count != '0);

  assign fetch_fire        = fetch_valid && fetch_ready;
  assign resolve_fire      = resolve_valid && resolve_ready;
  assign start_rollback    = (state_q == UPDATE) && mispredict_q;
  assign gp_predict_enable = fetch_fire;
  assign fetch_taken       = fetch_fire && gp_prediction;
  assign gp_pc_read        = fetch_pc;
  assign fsm_state         = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (resolve_fire) state_d = UPDATE;
      UPDATE:   state_d = mispredict_q ? ROLLBACK : IDLE;
      ROLLBACK: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Checkpoint storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (fetch_fire) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      hist_mem[wr_ptr] <= gp_history;
      pred_mem[wr_ptr] <= gp_prediction;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      inflight_count      <= '0;
      mispredict_q        <= 1'b0;
      gp_write_enabled    <= 1'b0;
      gp_rollback_enabled <= 1'b0;
      mispredict_flush    <= 1'b0;
      gp_pc_write         <= '0;
      gp_history_write    <= '0;
      gp_outcome          <= 1'b0;
    end else begin
      gp_write_enabled    <= resolve_fire;
      gp_rollback_enabled <= start_rollback;
      mispredict_flush    <= start_rollback;

      if (resolve_fire) begin
        gp_pc_write      <= pc_mem[rd_ptr];
        gp_history_write <= hist_mem[rd_ptr];
        gp_outcome       <= resolve_taken;
        mispredict_q     <= (resolve_taken != pred_mem[rd_ptr]);
      end else if (start_rollback) begin
        // Restored history is the checkpoint shifted by the real outcome.
        gp_history_write <= {gp_history_write[HISTORY_LEN-2:0], gp_outcome};
      end

      if (start_rollback) begin
        // Every younger branch is squashed, so the FIFO empties on entry to ROLLBACK.
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        inflight_count <= '0;
      end else begin
        if (fetch_fire)   wr_ptr <= wr_ptr + PW'(1);
        if (resolve_fire) rd_ptr <= rd_ptr + PW'(1);
        case ({fetch_fire, resolve_fire})
          2'b10:   inflight_count <= inflight_count + CW'(1);
          2'b01:   inflight_count <= inflight_count - CW'(1);
          default: inflight_count <= inflight_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_checkpoint_ctrl.sv
// Randomized and directed bench for branch_checkpoint_ctrl with a queue-based
// reference model and a scoreboard monitor for PHT writes and rollbacks.
module tb_branch_checkpoint_ctrl;
  localparam int HL    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_valid, resolve_valid, resolve_taken, gp_prediction;
  logic [15:0]   fetch_pc;
  logic [HL-1:0] gp_history;
  logic          fetch_ready, fetch_taken, resolve_ready, mispredict_flush;
  logic [CW-1:0] inflight_count;
  logic [15:0]   gp_pc_read, gp_pc_write;
  logic          gp_predict_enable, gp_write_enabled, gp_outcome, gp_rollback_enabled;
  logic [HL-1:0] gp_history_write;
  logic [1:0]    fsm_state;

  branch_checkpoint_ctrl #(.HISTORY_LEN(HL), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .fetch_taken(fetch_taken), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_ready(resolve_ready), .mispredict_flush(mispredict_flush),
    .inflight_count(inflight_count), .gp_prediction(gp_prediction), .gp_history(gp_history),
    .gp_pc_read(gp_pc_read), .gp_predict_enable(gp_predict_enable), .gp_pc_write(gp_pc_write),
    .gp_history_write(gp_history_write), .gp_write_enabled(gp_write_enabled),
    .gp_outcome(gp_outcome), .gp_rollback_enabled(gp_rollback_enabled), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0]   pc;
    logic [HL-1:0] hist;
    logic          pred;
  } entry_t;

  entry_t          model_q[$];
  logic [24:0]     exp_wr_q[$];
  int              exp_wr_cyc[$];
  logic [HL-1:0]   exp_rb_q[$];
  int              exp_rb_cyc[$];
  bit              upd_now = 0, upd_ok = 0, rb_now = 0;
  int              checks = 0, failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: one call is one clock cycle of stimulus plus model advance
  task automatic step(bit fv, logic [15:0] pc, bit pred, logic [HL-1:0] hist, bit rv, bit rt);
    bit exp_fr, exp_rr, ff, rf, next_rb;
    entry_t e;
    @(negedge clk);
    fetch_valid = fv; fetch_pc = pc; gp_prediction = pred; gp_history = hist;
    resolve_valid = rv; resolve_taken = rt;
    #1;
    exp_fr = !rb_now && (!upd_now || upd_ok) && (model_q.size() < DEPTH);
    exp_rr = !rb_now && !upd_now && (model_q.size() > 0);
    ff = fv && exp_fr;
    rf = rv && exp_rr;
    check("inflight_count", 32'(inflight_count), 32'(model_q.size()));
    check("fetch_ready", 32'(fetch_ready), 32'(exp_fr));
    check("resolve_ready", 32'(resolve_ready), 32'(exp_rr));
    check("predict_enable", 32'(gp_predict_enable), 32'(ff));
    if (ff) check("fetch_taken", 32'(fetch_taken), 32'(pred));
    check("pc_read", 32'(gp_pc_read), 32'(pc));
    next_rb = upd_now && !upd_ok;
    if (next_rb) model_q.delete();
    if (rf) begin
      e = model_q.pop_front();
      exp_wr_q.push_back({e.pc, e.hist, rt});
      exp_wr_cyc.push_back(cyc + 1);
      upd_ok = (rt == e.pred);
      if (!upd_ok) begin
        exp_rb_q.push_back({e.hist[HL-2:0], rt});
        exp_rb_cyc.push_back(cyc + 2);
      end
    end
    if (ff) model_q.push_back('{pc, hist, pred});
    rb_now  = next_rb;
    upd_now = rf;
  endtask

  task automatic idle_step();
    step(0, 16'h0, 0, '0, 0, 0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_count"}, 32'(inflight_count), 0);
    check({tag, "_write_en"}, 32'(gp_write_enabled), 0);
    check({tag, "_rollback"}, 32'(gp_rollback_enabled), 0);
    check({tag, "_flush"}, 32'(mispredict_flush), 0);
    check({tag, "_pc_write"}, 32'(gp_pc_write), 0);
    check({tag, "_hist_write"}, 32'(gp_history_write), 0);
    check({tag, "_outcome"}, 32'(gp_outcome), 0);
  endtask

  // scoreboard monitor: pops expectations whenever the DUT strobes
  initial begin
    logic [24:0] w;
    int c;
    forever begin
      @(negedge clk);
      #1;
      if (gp_write_enabled) begin
        if (exp_wr_q.size() == 0) check("write_unexpected", 32'(gp_write_enabled), 0);
        else begin
          w = exp_wr_q.pop_front();
          c = exp_wr_cyc.pop_front();
          check("write_pc", 32'(gp_pc_write), 32'(w[24:9]));
          check("write_hist", 32'(gp_history_write), 32'(w[8:1]));
          check("write_outcome", 32'(gp_outcome), 32'(w[0]));
          check("write_latency", cyc, c);
        end
      end else if (exp_wr_cyc.size() != 0 && exp_wr_cyc[0] <= cyc)
        check("write_missing", 32'(gp_write_enabled), 1);
      if (gp_rollback_enabled) begin
        if (exp_rb_q.size() == 0) check("rollback_unexpected", 32'(gp_rollback_enabled), 0);
        else begin
          check("rollback_hist", 32'(gp_history_write), 32'(exp_rb_q.pop_front()));
          check("rollback_latency", cyc, exp_rb_cyc.pop_front());
          check("rollback_flush", 32'(mispredict_flush), 1);
          check("rollback_count", 32'(inflight_count), 0);
          check("rollback_fetch_ready", 32'(fetch_ready), 0);
        end
      end else if (exp_rb_cyc.size() != 0 && exp_rb_cyc[0] <= cyc)
        check("rollback_missing", 32'(gp_rollback_enabled), 1);
      if (mispredict_flush && !gp_rollback_enabled)
        check("flush_stray", 32'(mispredict_flush), 0);
    end
  end

  initial begin
    entry_t head;
    reset = 1'b0;
    fetch_valid = 0; fetch_pc = '0; gp_prediction = 0; gp_history = '0;
    resolve_valid = 0; resolve_taken = 0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // single correct branch
    step(1, 16'h0010, 1, 8'h00, 0, 0);
    step(0, 16'h0, 0, 8'h00, 1, 1);
    repeat (3) idle_step();

    // mispredict with flush of younger branches
    step(1, 16'h0100, 1, 8'h05, 0, 0);
    step(1, 16'h0104, 1, 8'h0A, 0, 0);
    step(1, 16'h0108, 0, 8'h15, 0, 0);
    step(0, 16'h0, 0, 8'h00, 1, 0);
    repeat (4) step(1, 16'h0200, 1, 8'h33, 0, 0);
    repeat (2) step(0, 16'h0, 0, 8'h00, 1, 1);
    repeat (3) idle_step();

    // full FIFO, then simultaneous push/pop, then fetch during a correct UPDATE
    for (int i = 0; i < 6; i++) step(1, 16'h0300 + 16'(i), 1, 8'(i), 0, 0);
    head = model_q[0];
    step(1, 16'h03F0, 1, 8'hAA, 1, head.pred);
    step(1, 16'h03F4, 0, 8'hBB, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 16'h0, 0, 8'h00, 1, (model_q.size() > 0) ? model_q[0].pred : 1'b0);
    repeat (3) idle_step();

    // wrap-around: alternating fetch/resolve pairs
    for (int i = 0; i < 10; i++) begin
      step(1, 16'($urandom_range(0, 65535)), 1, 8'($urandom_range(0, 255)), 0, 0);
      step(0, 16'h0, 0, 8'h00, 1, 1);
    end
    repeat (3) idle_step();

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
    repeat (4) idle_step();

    // reset in the middle of a mispredicting UPDATE
    step(1, 16'h0500, 1, 8'h11, 0, 0);
    step(0, 16'h0, 0, 8'h00, 1, 0);
    @(negedge clk);
    fetch_valid = 0; resolve_valid = 0;
    #3;
    reset = 1'b0;
    model_q.delete(); exp_rb_q.delete(); exp_rb_cyc.delete();
    exp_wr_q.delete(); exp_wr_cyc.delete();
    upd_now = 0; upd_ok = 0; rb_now = 0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) idle_step();
    check("end_wr_queue_empty", 32'(exp_wr_q.size()), 0);
    check("end_rb_queue_empty", 32'(exp_rb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_checkpoint_ctrl.md
Name: branch_checkpoint_ctrl

Overview:
Sequencing controller for the gshare predictor. It issues predictions for fetched branches and checkpoints each branch's PC, pre-shift global history and prediction in an in-order FIFO. At in-order resolution it drives the pattern-history-table update. On a mispredict it restores the corrected global history and flushes all younger in-flight branches.

Parameters:
HISTORY_LEN, 8, global history width; must match the predictor.
DEPTH, 4, maximum number of in-flight (unresolved) branches; power of 2, at least 2.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
fetch_valid  input  1  fetch stage presents a branch.
fetch_pc  input  16  PC of the fetched branch.
fetch_ready  output  1  controller can accept a branch this cycle.
fetch_taken  output  1  prediction for the accepted branch; combinational, valid when fetch_valid & fetch_ready.
resolve_valid  input  1  oldest in-flight branch has resolved.
resolve_taken  input  1  actual outcome (1 = taken).
resolve_ready  output  1  controller accepts the resolution.
mispredict_flush  output  1  one-cycle pulse; pipeline squashes all younger branches.
inflight_count  output  $clog2(DEPTH)+1  number of occupied FIFO entries.
gp_prediction  input  1  predictor prediction output.
gp_history  input  HISTORY_LEN  predictor current global history.
gp_pc_read  output  16  equals fetch_pc (combinational).
gp_predict_enable  output  1  shifts the predictor history.
gp_pc_write  output  16  PC of the branch being updated.
gp_history_write  output  HISTORY_LEN  history for the update or rollback.
gp_write_enabled  output  1  PHT update strobe.
gp_outcome  output  1  outcome used for the PHT update.
gp_rollback_enabled  output  1  history restore strobe.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied; state IDLE.
  - All registered outputs are 0: gp_write_enabled, gp_rollback_enabled, mispredict_flush, gp_pc_write, gp_history_write, gp_outcome, inflight_count.
  - A reset in the middle of UPDATE or ROLLBACK aborts the sequence with no further strobes.
- States:
  - IDLE: normal operation.
  - UPDATE: one cycle, PHT write.
  - ROLLBACK: one cycle, history restore.
- Fetch handshake:
  - fetch_ready = (state==IDLE, or state==UPDATE with a correct prediction) && inflight_count<DEPTH.
  - A fetch fires on fetch_valid & fetch_ready. In the same cycle: gp_predict_enable=1 and fetch_taken=gp_prediction.
  - At the clock edge the controller pushes {fetch_pc, gp_history (pre-shift), gp_prediction}.
  - gp_predict_enable = fetch_valid & fetch_ready; it is never 1 in ROLLBACK.
- Resolve handshake:
  - resolve_ready = state==IDLE && inflight_count>0.
  - On the firing edge the controller pops the oldest entry into holding registers and records mispredict = (resolve_taken != stored prediction).
  - The state then moves to UPDATE.
- UPDATE state:
  - gp_write_enabled=1, gp_pc_write=entry pc, gp_history_write=entry history, gp_outcome=resolve_taken.
  - Next state is IDLE if the prediction was correct, otherwise ROLLBACK.
- ROLLBACK state:
  - gp_rollback_enabled=1, gp_history_write={entry_history[HISTORY_LEN-2:0], resolve_taken}, mispredict_flush=1.
  - The FIFO is cleared (count becomes 0); next state IDLE.
- Latency: resolve accept to PHT write is 1 cycle; to rollback it is 2 cycles. After a mispredict, fetch is blocked for 2 cycles.
- FIFO rules:
  - Circular buffer; pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle leave the count unchanged.
  - fetch_ready uses the count before any pop, so there is no push when full even if a pop occurs that cycle.
- Resolve with an empty FIFO: resolve_ready=0 and nothing changes.
- Unheld strobe outputs are 0. Data outputs hold their last values.

Test Plan:
- Single correct branch:
  - Stimulus: reset; fetch pc=0x0010 with gp_prediction=1, gp_history=0x00; next cycle resolve taken=1.
  - Required: predict_enable pulses at fetch; one cycle after the resolve is accepted, write_enabled=1 with pc_write=0x0010, history_write=0x00, outcome=1.
  - Required: no rollback; inflight_count returns 0.
- Mispredict with flush:
  - Stimulus: 3 fetches with histories 0x05, 0x0A, 0x15 and predictions 1,1,0; resolve the oldest with taken=0.
  - Required: UPDATE writes history 0x05 with outcome=0.
  - Required: next cycle rollback_enabled=1, history_write=0x0A, mispredict_flush=1, inflight_count=0.
  - Required: fetch_ready=0 in both cycles.
- Full FIFO:
  - Stimulus: DEPTH=4; hold fetch_valid high for 6 cycles.
  - Required: exactly 4 pushes; fetch_ready=0 at count 4; predict_enable never asserted while fetch_ready=0.
- Simultaneous push and pop:
  - Stimulus: count=4; fetch and resolve both valid.
  - Required: pop occurs, push is refused (count 3).
  - Required: in the following UPDATE of a correct branch, a fetch is accepted with write_enabled and predict_enable both 1.
- Wrap-around:
  - Stimulus: 10 alternating fetch/resolve pairs with correct predictions.
  - Required: each pc_write matches its fetch_pc in order.
- Reset mid-sequence:
  - Stimulus: assert reset during UPDATE of a mispredicting branch.
  - Required: rollback_enabled never pulses; all outputs 0; count 0.
